// File: rtl/keypad_scan_capture.sv
// keypad_scan_capture: scans a 4x4 active-low matrix keypad one row at a time,
// debounces a single key press and release, and presents the key code together
// with a one-cycle capture strobe for a downstream 4-bit register.
//
// Output handshake: key_valid_o is a valid-only strobe with no ready. It is high
// for exactly one cycle, key_o changes only in that cycle, and the consumer is
// expected to capture key_o whenever key_valid_o is high.
`timescale 1ns/1ps

module keypad_scan_capture #(
  parameter int SCAN_DIV  = 10000,
  parameter int DB_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [3:0]        COL_IDLE  = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Returns {valid, index}: valid only when exactly one column is pulled low.
  // Two or more low columns (ghosting) decode as invalid and are ignored.
  function automatic logic [2:0] decode_col(input logic [3:0] c);
    case (c)
      4'b1110: decode_col = 3'b100;
      4'b1101: decode_col = 3'b101;
      4'b1011: decode_col = 3'b110;
      4'b0111: decode_col = 3'b111;
      default: decode_col = 3'b000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]        pat_q, pat_d;
  logic              pend_q, pend_d;
  logic [3:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic [3:0] col_s;
  logic [2:0] col_dec;
  logic [2:0] pat_dec;

  assign col_s       = sync2_q;
  assign col_dec     = decode_col(col_s);
  assign pat_dec     = decode_col(pat_q);
  assign row_o       = row_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

  // Next-state logic: synchronizer, row scan, debounce/hold/release sequencing
  // and the registered key outputs.
  always_comb begin
    state_d     = state_q;
    sync1_d     = col_i;
    sync2_d     = sync1_q;
    row_idx_d   = row_idx_q;
    row_d       = row_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    pat_d       = pat_q;
    pend_d      = 1'b0;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    // The press was accepted last cycle; load the code and strobe once.
    // The row is still frozen on the pressed key's row here.
    if (pend_q) begin
      key_d       = {row_idx_q, pat_dec[1:0]};
      key_valid_d = 1'b1;
    end

    case (state_q)
      ST_SCAN: begin
        key_held_d = 1'b0;
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (col_dec[2]) begin
            pat_d    = col_s;
            db_cnt_d = '0;
            state_d  = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (col_s == pat_q) begin
          if (db_cnt_q == DB_LAST) begin
            db_cnt_d   = '0;
            pend_d     = 1'b1;
            key_held_d = 1'b1;
            state_d    = ST_HELD;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          row_idx_d  = row_idx_q + 2'd1;
          row_d      = {row_q[2:0], row_q[3]};
          state_d    = ST_SCAN;
        end
      end

      ST_HELD: begin
        key_held_d = 1'b1;
        if (col_s == COL_IDLE) begin
          db_cnt_d = '0;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (col_s == COL_IDLE) begin
          if (db_cnt_q == DB_LAST) begin
            db_cnt_d   = '0;
            key_held_d = 1'b0;
            scan_cnt_d = '0;
            row_idx_d  = row_idx_q + 2'd1;
            row_d      = {row_q[2:0], row_q[3]};
            state_d    = ST_SCAN;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
          state_d  = ST_HELD;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      pat_q       <= 4'b1111;
      pend_q      <= 1'b0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      pat_q       <= pat_d;
      pend_q      <= pend_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_capture.sv
// Bench for keypad_scan_capture: a keypad model drives col_i from row_o and a
// per-row set of pressed keys; expected rows, strobe times and codes are
// predicted arithmetically from the scan origin (cycle and row at which plain
// scanning last started).
`timescale 1ns/1ps

module tb_keypad_scan_capture;

  localparam int SD  = 4;
  localparam int DB  = 8;
  localparam int BIG = 32'h3fff_ffff;

  logic       clk;
  logic       rst;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_held_o;

  logic [3:0] pressed [4];
  int         total = 0;
  int         bad   = 0;
  int         cyc;
  int         org_cyc;
  int         org_row;
  logic [3:0] last_code;

  keypad_scan_capture #(.SCAN_DIV(SD), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_i       (col_i),
    .row_o       (row_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_held_o  (key_held_o)
  );

  // Clock: 100 ns period.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Keypad: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_i = 4'b1111;
    for (int i = 0; i < 4; i++)
      if (row_o[i] == 1'b0) col_i = col_i & ~pressed[i];
  end

  // Posedges since the last reset release.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #(50000 * 100);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [3:0] row_pat(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (idx % 4));
  endfunction

  // Row expected while scanning freely since the origin.
  function automatic logic [3:0] exp_row();
    return row_pat(org_row + (cyc - org_cyc) / SD);
  endfunction

  // First row-slot end at or after tp+3 (two sync flops plus the pin change)
  // that belongs to row r.
  function automatic int sample_edge(input int tp, input int r);
    int m;
    m = 1;
    while (!((org_cyc + SD * m >= tp + 3) && ((org_row + m - 1) % 4 == r))) m++;
    return org_cyc + SD * m;
  endfunction

  // Step until cyc==target with no strobe; rows follow the scan until the
  // sampling edge e, then stay frozen on row r.
  task automatic wait_check(input int target, input int e, input int r, input string tag);
    while (cyc < target) begin
      tick();
      chk({tag, "_valid"}, key_valid_o, 1'b0);
      chk({tag, "_key"}, key_o, last_code);
      chk({tag, "_row"}, row_o, (cyc < e) ? exp_row() : row_pat(r));
      chk({tag, "_held"}, key_held_o, (cyc >= e + DB) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_row"}, row_o, 4'b1110);
    chk({tag, "_key"}, key_o, 4'h0);
    chk({tag, "_valid"}, key_valid_o, 1'b0);
    chk({tag, "_held"}, key_held_o, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    org_cyc   = 0;
    org_row   = 0;
    last_code = 4'h0;
  endtask

  task automatic press(input int r, input int c, output int e);
    pressed[r][c] = 1'b1;
    e = sample_edge(cyc, r);
  endtask

  // Strobe lands DB+1 cycles after the sampling edge.
  task automatic expect_strobe(input int e, input int r, input logic [3:0] code, input string tag);
    wait_check(e + DB, e, r, tag);
    tick();
    chk({tag, "_strobe"}, key_valid_o, 1'b1);
    chk({tag, "_code"}, key_o, code);
    chk({tag, "_held_at_strobe"}, key_held_o, 1'b1);
    chk({tag, "_row_frozen"}, row_o, row_pat(r));
    last_code = code;
  endtask

  task automatic after_strobe(input string tag);
    tick();
    chk({tag, "_single"}, key_valid_o, 1'b0);
    chk({tag, "_key_kept"}, key_o, last_code);
  endtask

  // Release all keys of row r; held drops DB+3 cycles later and scanning
  // restarts on the following row.
  task automatic release_key(input int r, input string tag);
    int tr;
    pressed[r] = 4'b0000;
    tr = cyc;
    org_cyc = tr + DB + 3;
    org_row = (r + 1) % 4;
    for (int k = 1; k <= DB + 3; k++) begin
      tick();
      chk({tag, "_valid"}, key_valid_o, 1'b0);
      chk({tag, "_key"}, key_o, last_code);
      if (k < DB + 3) begin
        chk({tag, "_held"}, key_held_o, 1'b1);
        chk({tag, "_row"}, row_o, row_pat(r));
      end else begin
        chk({tag, "_held_fall"}, key_held_o, 1'b0);
        chk({tag, "_row_resume"}, row_o, exp_row());
      end
    end
  endtask

  initial begin
    int e;
    int r;
    int c;
    int ts;
    int n_strobe;
    logic [3:0] code;

    for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;
    rst = 1'b0;
    #5;

    // 1: reset values and idle scanning for 100 cycles.
    apply_reset("reset");
    wait_check(100, BIG, 0, "idle");

    // 2: clean press of row 2 / col 1.
    press(2, 1, e);
    expect_strobe(e, 2, 4'h9, "clean");
    after_strobe("clean");
    wait_check(cyc + 5, 0, 2, "clean_hold");
    release_key(2, "clean_rel");

    // 3: bouncy press of row 2 / col 1, then stable.
    for (int k = 0; k < 30; k++) begin
      pressed[2][1] = ((k / 3) % 2 == 0);
      tick();
      chk("bounce_valid", key_valid_o, 1'b0);
      chk("bounce_held", key_held_o, 1'b0);
    end
    pressed[2][1] = 1'b1;
    ts = cyc;
    n_strobe = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (key_valid_o) begin
        n_strobe++;
        chk("bounce_code", key_o, 4'h9);
        chk("bounce_not_early", (cyc >= ts + DB + 4) ? 1'b1 : 1'b0, 1'b1);
        last_code = 4'h9;
      end else begin
        chk("bounce_key_kept", key_o, last_code);
      end
    end
    chk("bounce_strobes", n_strobe, 1);
    chk("bounce_held_after", key_held_o, 1'b1);

    // 4: release bounce, then clean release.
    pressed[2] = 4'b0000;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) pressed[2][1] = 1'b1;
      tick();
      chk("relbounce_valid", key_valid_o, 1'b0);
      chk("relbounce_held", key_held_o, 1'b1);
    end
    release_key(2, "relbounce_final");
    wait_check(cyc + 2 * SD, BIG, 0, "resume_scan");

    // 5: ghost (two columns on row 0) is ignored, then row 3 / col 3.
    pressed[0] = 4'b0110;
    wait_check(cyc + 40, BIG, 0, "ghost");
    pressed[0] = 4'b0000;
    wait_check(cyc + 3, BIG, 0, "ghost_clear");
    press(3, 3, e);
    expect_strobe(e, 3, 4'hF, "r3c3");
    after_strobe("r3c3");
    release_key(3, "r3c3_rel");

    // Random keys with random idle gaps and hold times.
    for (int n = 0; n < 5; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      code = 4'(r * 4 + c);
      wait_check(cyc + $urandom_range(0, 20), BIG, 0, "rnd_gap");
      press(r, c, e);
      expect_strobe(e, r, code, "rnd");
      after_strobe("rnd");
      wait_check(cyc + $urandom_range(0, 6), 0, r, "rnd_hold");
      release_key(r, "rnd_rel");
    end

    // 6a: reset three cycles into the debounce; a fresh full debounce follows.
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    code = 4'(r * 4 + c);
    press(r, c, e);
    wait_check(e + 3, e, r, "pre_rst_db");
    apply_reset("rst_db");
    e = sample_edge(0, r);
    expect_strobe(e, r, code, "post_rst_db");

    // 6b: reset in the strobe cycle; again a full debounce is required.
    apply_reset("rst_strobe");
    e = sample_edge(0, r);
    expect_strobe(e, r, code, "post_rst_strobe");
    after_strobe("post_rst_strobe");
    release_key(r, "final_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_capture.md
Name: keypad_scan_capture

Overview:
- Scans a 4x4 matrix keypad, debounces the press and encodes it as a 4-bit key code.
- Emits a one-cycle capture strobe per press.
- Sits directly upstream of the 4-bit capture register: key_o drives the register data inputs (bit 3 to bit 0); key_valid_o drives its clock-enable.
- Runs in the same 10 MHz clock domain as that register.

Parameters:
- SCAN_DIV, default 10000: clock cycles each row stays driven during scanning (1 ms at 10 MHz); minimum 2.
- DB_CYCLES, default 100000: consecutive stable cycles required to accept a press or a release (10 ms at 10 MHz); minimum 2.

Ports:
- clk  input  1  system clock (10 MHz domain).
- rst  input  1  asynchronous, active-high reset.
- col_i  input  4  keypad columns; asynchronous, active-low, externally pulled up.
- row_o  output  4  keypad row drive; one-hot-low, exactly one bit 0 at all times.
- key_o  output  4  code of the last accepted key; held until the next accepted press.
- key_valid_o  output  1  one-cycle pulse in the cycle key_o updates; feeds the register CE.
- key_held_o  output  1  high while an accepted key is still pressed or its release is being debounced.

Behaviour:
- Reset values (async, rst=1):
  - row_o=4'b1110, key_o=4'h0, key_valid_o=0, key_held_o=0.
  - FSM=SCAN, row index=0, all counters 0, synchronizer flops=4'b1111.
- Input conditioning:
  - col_i passes through a 2-flop synchronizer; all decisions use the synchronized value colS.
  - Latency from pin to colS is 2 cycles.
- Column decode:
  - colS is valid when exactly one bit is 0; col index = position of that 0.
  - colS=4'b1111 is idle.
  - Two or more zeros is invalid (ghosting) and is treated as idle.
- Key code: key_o = {row_idx[1:0], col_idx[1:0]}, e.g. row 2 with col 1 gives 4'h9.
- FSM SCAN:
  - Scan counter counts 0..SCAN_DIV-1 per row; colS is sampled only at count SCAN_DIV-1 (settle time).
  - If the sample is valid: store row_idx and the colS pattern, clear the debounce counter, go to DEBOUNCE. row_o stays frozen on the current row.
  - Otherwise: advance the row (0,1,2,3,0...), rotate row_o left (1110, 1101, 1011, 0111, 1110), reset the scan counter.
- FSM DEBOUNCE (row frozen):
  - Each cycle colS equals the stored pattern: the counter increments.
  - Any mismatch: go to SCAN, counter cleared, scanning resumes at the next row.
  - When the counter reaches DB_CYCLES-1 with a match: in the next cycle key_o is loaded and key_valid_o=1 for exactly that cycle; go to HELD.
  - Total from first sampled press to strobe is DB_CYCLES+1 cycles.
- FSM HELD (row frozen):
  - key_held_o=1.
  - colS==4'b1111: clear the counter, go to RELEASE.
  - Any other value, including a second key on the same row: stay in HELD, no new strobe (no auto-repeat, no rollover).
- FSM RELEASE (row frozen):
  - key_held_o=1.
  - colS stays 4'b1111 for DB_CYCLES consecutive cycles: key_held_o=0, go to SCAN. The scan restarts at the next row with the scan counter at 0.
  - Any 0 in colS before then: go back to HELD, counter cleared, no strobe.
- Outputs are registered; key_valid_o is never high for two consecutive cycles.
- key_o changes only in the cycle key_valid_o=1.
- Reset mid-operation (any state, including the strobe cycle): all outputs take their reset values immediately. No strobe is issued after rst falls until a full new debounce completes.
- Counter widths: $clog2 of the parameter; no counter wraps unobserved.

Test Plan (SCAN_DIV=4, DB_CYCLES=8 unless noted):
1. Reset with col_i=1111:
   - row_o cycles 1110, 1101, 1011, 0111, 1110, each row held for 4 cycles.
   - key_valid_o stays 0 and key_o=0 for 100 cycles.
2. Clean press of row 2 / col 1 (col_i=1101 while row_o=1011):
   - Exactly one key_valid_o pulse with key_o=4'h9, 9 cycles after the sampling edge.
   - key_held_o=1; row_o frozen at 1011.
3. Bouncy press, col_i toggling 1101/1111 every 3 cycles for 30 cycles then stable:
   - No strobe during bouncing; exactly one strobe with the correct code after 8 stable cycles.
4. Release bounce (key held, then col_i toggles to 1111 for 5 cycles, back to 1101, then 1111 for 8+ cycles):
   - Single strobe only; key_held_o falls only after the final 8 clean cycles; scanning resumes.
5. Two columns low (col_i=1001) on row 0:
   - No strobe; scanning continues.
   - Then a single key row 3 / col 3 gives key_o=4'hF.
6. rst asserted 3 cycles into DEBOUNCE, and separately in the strobe cycle:
   - Outputs return to reset values asynchronously; no strobe until a fresh full debounce.
